multibit_stable_filter: RTL and testbench
=========================================

MULTIBIT_STABLE_FILTER -- requirements
Module: multibit_stable_filter

Interface
REQ-001 Parameter DW, default 32: bus width in bits.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before commit; legal range 2..255.
REQ-003 Parameter RST_VAL, default {DW{1'b1}}: reset value of data_o and of the internal sample register.
REQ-004 Parameter TIMEOUT, default 64: maximum SETTLE cycles before error. Used only with the macro in REQ-024.
REQ-005 clki  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 sync_data_i  input  DW  per-bit synchronized bus from the multibit synchronizer; bits may skew by one or more cycles.
REQ-008 data_o  output  DW  coherent committed value, registered.
REQ-009 upd_o  output  1  one-cycle pulse, registered, when data_o takes a new value.
REQ-010 busy_o  output  1  high while in SETTLE state, registered.
REQ-011 err_o  output  1  sticky settle-timeout flag, registered.

Function
REQ-012 Internal registers: last_q (DW, previous sample), cnt (8 bits, stable count) and state (IDLE/SETTLE).
- last_q loads sync_data_i every cycle.
REQ-013 IDLE: if sync_data_i != data_o, go to SETTLE with cnt=0 and busy_o=1 the next cycle. Otherwise stay in IDLE.
REQ-014 SETTLE: each cycle, compare sync_data_i with last_q.
- If equal, cnt increments.
- If different, cnt clears to 0 (restart; covers a third value arriving mid-settle).
REQ-015 SETTLE, sync_data_i == last_q and cnt == STABLE_CYCLES-2: commit.
- data_o loads sync_data_i and upd_o=1 for one cycle.
- Return to IDLE with cnt=0.
REQ-016 Latency: a value first sampled at edge N and held constant appears on data_o after edge N+STABLE_CYCLES-1, with upd_o high during the same cycle. For default STABLE_CYCLES=4, that is 3 edges later.
REQ-017 SETTLE, sync_data_i == data_o with cnt not yet at commit (glitch reverted): return to IDLE, cnt=0, no upd_o, data_o unchanged.
REQ-018 upd_o is never high on two consecutive cycles.
- A change arriving in the commit cycle is evaluated from IDLE on the next cycle.
REQ-019 data_o never takes a value that was not presented on sync_data_i for STABLE_CYCLES consecutive cycles.
REQ-020 cnt saturates and never wraps. No arithmetic exceeds 8 bits.

Reset
REQ-021 While rst=1 at an edge:
- data_o=RST_VAL and last_q=RST_VAL.
- state=IDLE and cnt=0.
- upd_o=0, busy_o=0 and err_o=0.
REQ-022 Reset asserted mid-SETTLE aborts without commit.
- The first post-reset cycle is IDLE and compares against RST_VAL.
REQ-023 rst has priority over every other event at the same edge.

Configuration
REQ-024 Macro MULTIBIT_STABLE_FILTER_TIMEOUT_EN defined: a 16-bit settle timer counts cycles spent in SETTLE.
- The timer clears on entry to IDLE.
- When the timer reaches TIMEOUT, err_o sets and stays high until rst.
- The FSM keeps running unaffected.
REQ-025 Macro undefined: no timer logic; err_o is tied constantly to 0.
- Port list is identical in both builds.

Verification
REQ-026 Reset: hold rst 2 cycles, DW=32 default -> data_o=0xFFFFFFFF, upd_o=0, busy_o=0, err_o=0.
REQ-027 Clean change: sync_data_i 0xFFFFFFFF->0x0000A5A5, then held -> data_o=0x0000A5A5 and a single upd_o pulse exactly 3 edges after the first sampling edge.
REQ-028 Skewed arrival: 0x0000A5A5 -> 0x00005A5A -> 0x0000FFFF -> hold, one cycle each before the hold.
- Required: count restarts on each change; only 0x0000FFFF is committed; exactly one upd_o pulse.
REQ-029 Glitch: 0x00000000 committed, then 0x00000001 for 1 cycle, then back to 0x00000000 -> busy_o high 1 cycle, no upd_o, data_o stays 0x00000000.
REQ-030 Reset mid-SETTLE: change to 0x12345678 and assert rst after 2 cycles -> no commit, data_o=0xFFFFFFFF.
- If 0x12345678 is still held after reset, commit occurs 3 edges after the first post-reset sample.
REQ-031 Timeout with macro, TIMEOUT=8: toggle sync_data_i between 0x1 and 0x2 every cycle -> err_o rises after 8 SETTLE cycles and stays high.
- Without the macro, the same stimulus leaves err_o=0.

Source files
------------

// File: rtl/multibit_stable_filter.sv
// -----------------------------------------------------------------------------
// multibit_stable_filter
//
// Purpose: sits behind a per-bit multibit synchronizer. The bits of that bus
// can land on different cycles, so this block only publishes a value once it
// has been seen unchanged for STABLE_CYCLES consecutive samples. Each publish
// is marked by a one-cycle update pulse.
//
// Parameters:
//   DW            bus width
//   STABLE_CYCLES consecutive identical samples needed before a commit (2..255)
//   RST_VAL       reset value of data_o and of the previous-sample register
//   TIMEOUT       maximum number of SETTLE cycles before err_o sets
//                 (only used when the optional build macro is defined)
//
// Ports:
//   clki         in   1   clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   sync_data_i  in   DW  per-bit synchronized bus (bits may be skewed)
//   data_o       out  DW  committed coherent value, registered
//   upd_o        out  1   one-cycle pulse when data_o takes a new value
//   busy_o       out  1   high while the FSM is in SETTLE
//   err_o        out  1   sticky settle-timeout flag
//
// Build option:
//   MULTIBIT_STABLE_FILTER_TIMEOUT_EN  adds a 16-bit settle timer that drives
//   err_o. When it is undefined there is no timer and err_o is held at 0.
//   The port list is the same in both builds.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | input matches data_o; a difference starts a settle run
// SETTLE | counting identical consecutive samples toward a commit
// -----------------------------------------------------------------------------
module multibit_stable_filter #(
    parameter int unsigned     DW            = 32,
    parameter int unsigned     STABLE_CYCLES = 4,
    parameter logic [DW-1:0]   RST_VAL       = {DW{1'b1}},
    parameter int unsigned     TIMEOUT       = 64
) (
    input  logic          clki,
    input  logic          rst,
    input  logic [DW-1:0] sync_data_i,
    output logic [DW-1:0] data_o,
    output logic          upd_o,
    output logic          busy_o,
    output logic          err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // The cycle that enters SETTLE is already the first identical sample, so
    // the commit happens when cnt reaches STABLE_CYCLES-2.
    localparam logic [7:0] COMMIT_CNT = 8'(STABLE_CYCLES - 2);

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] last_q;
    logic [7:0]    cnt;
    logic [7:0]    cnt_n;
    logic          commit;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (sync_data_i != data_o) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_data_i == data_o) begin
                    // glitch reverted to the committed value: abandon quietly
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (sync_data_i == last_q) begin
                    if (cnt == COMMIT_CNT) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt != 8'hFF) begin
                        cnt_n = cnt + 8'd1;
                    end
                end else begin
                    // another bit landed (or a third value arrived): restart
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= RST_VAL;
            data_o <= RST_VAL;
            upd_o  <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last_q <= sync_data_i;
            upd_o  <= commit;
            busy_o <= (state_n == SETTLE);
            if (commit) begin
                data_o <= sync_data_i;
            end
        end
    end

`ifdef MULTIBIT_STABLE_FILTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    // timer holds the number of completed SETTLE cycles; it is zero in IDLE
    logic [15:0] timer;

    always_ff @(posedge clki) begin
        if (rst) begin
            timer <= '0;
            err_o <= 1'b0;
        end else if (state == SETTLE) begin
            if (timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end
            if (timer == TIMEOUT_LAST) begin
                err_o <= 1'b1;
            end
        end else begin
            timer <= '0;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_multibit_stable_filter.sv
// -----------------------------------------------------------------------------
// tb_multibit_stable_filter
//
// Directed bench for multibit_stable_filter (DW=32, STABLE_CYCLES=4,
// TIMEOUT=8). Inputs change 1 ns after a rising edge, and outputs are read at
// the same point, so each read shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_multibit_stable_filter;

    logic        clki = 1'b0;
    logic        rst;
    logic [31:0] sync_data_i;
    logic [31:0] data_o;
    logic        upd_o;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    logic prev_upd = 1'b0;

    always #5 clki = ~clki;

    multibit_stable_filter #(
        .DW            (32),
        .STABLE_CYCLES (4),
        .RST_VAL       (32'hFFFF_FFFF),
        .TIMEOUT       (8)
    ) dut (
        .clki        (clki),
        .rst         (rst),
        .sync_data_i (sync_data_i),
        .data_o      (data_o),
        .upd_o       (upd_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle; also counts pulses and flags back-to-back upd_o
    task automatic tick();
        @(posedge clki);
        #1;
        if (upd_o) upd_cnt++;
        check_val("upd_not_consecutive", {31'b0, upd_o & prev_upd}, 32'h0);
        prev_upd = upd_o;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_data,
                              input logic e_upd, input logic e_busy);
        check_val({tag, "_data"}, data_o, e_data);
        check_val({tag, "_upd"},  {31'b0, upd_o},  {31'b0, e_upd});
        check_val({tag, "_busy"}, {31'b0, busy_o}, {31'b0, e_busy});
    endtask

    logic exp_err;

    initial begin
        // ---------------- reset ----------------
        rst         = 1'b1;
        sync_data_i = 32'hFFFF_FFFF;
        tick();
        tick();
        check_outs("reset", 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("reset_err", {31'b0, err_o}, 32'h0);
        rst = 1'b0;
        tick();
        check_outs("idle_after_reset", 32'hFFFF_FFFF, 1'b0, 1'b0);

        // ---------------- clean change: commit 3 edges after first sample ----------------
        upd_cnt     = 0;
        sync_data_i = 32'h0000_A5A5;
        tick();
        check_outs("clean_e0", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("clean_e1", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("clean_e2", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("clean_e3", 32'h0000_A5A5, 1'b1, 1'b0);
        tick();
        check_outs("clean_e4", 32'h0000_A5A5, 1'b0, 1'b0);
        check_val("clean_pulses", 32'(upd_cnt), 32'd1);

        // ---------------- skewed arrival ----------------
        upd_cnt     = 0;
        sync_data_i = 32'h0000_5A5A;
        tick();
        check_outs("skew_e0", 32'h0000_A5A5, 1'b0, 1'b1);
        sync_data_i = 32'h0000_FFFF;
        tick();
        check_outs("skew_e1", 32'h0000_A5A5, 1'b0, 1'b1);
        tick();
        check_outs("skew_e2", 32'h0000_A5A5, 1'b0, 1'b1);
        tick();
        check_outs("skew_e3", 32'h0000_A5A5, 1'b0, 1'b1);
        tick();
        check_outs("skew_e4", 32'h0000_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_val("skew_data_hold", data_o, 32'h0000_FFFF);
        check_val("skew_pulses", 32'(upd_cnt), 32'd1);

        // ---------------- glitch ----------------
        sync_data_i = 32'h0000_0000;
        for (int i = 0; i < 4; i++) tick();
        check_outs("glitch_setup", 32'h0000_0000, 1'b1, 1'b0);
        upd_cnt     = 0;
        sync_data_i = 32'h0000_0001;
        tick();
        check_outs("glitch_e0", 32'h0000_0000, 1'b0, 1'b1);
        sync_data_i = 32'h0000_0000;
        tick();
        check_outs("glitch_e1", 32'h0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_outs("glitch_after", 32'h0000_0000, 1'b0, 1'b0);
        check_val("glitch_pulses", 32'(upd_cnt), 32'd0);

        // ---------------- reset mid-SETTLE ----------------
        upd_cnt     = 0;
        sync_data_i = 32'h1234_5678;
        tick();
        tick();
        check_outs("rstmid_pre", 32'h0000_0000, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check_outs("rstmid_rst", 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("rstmid_pulses", 32'(upd_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check_outs("rstmid_m0", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("rstmid_m1", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("rstmid_m2", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick();
        check_outs("rstmid_m3", 32'h1234_5678, 1'b1, 1'b0);

        // ---------------- settle timeout (toggling input never commits) ----------------
        upd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            sync_data_i = (i % 2 == 0) ? 32'h0000_0001 : 32'h0000_0002;
            tick();
`ifdef MULTIBIT_STABLE_FILTER_TIMEOUT_EN
            exp_err = (i >= 8);
`else
            exp_err = 1'b0;
`endif
            check_val($sformatf("timeout_err_e%0d", i), {31'b0, err_o}, {31'b0, exp_err});
            check_val($sformatf("timeout_busy_e%0d", i), {31'b0, busy_o}, 32'h1);
        end
        check_val("timeout_data", data_o, 32'h1234_5678);
        check_val("timeout_pulses", 32'(upd_cnt), 32'd0);

        rst = 1'b1;
        tick();
        check_val("timeout_rst_err", {31'b0, err_o}, 32'h0);
        check_outs("timeout_rst", 32'hFFFF_FFFF, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
